// File: rtl/intersection_pkg.sv
// intersection_pkg: shared types and constants for the intersection controller.
//   state_t    - controller states; the 3-bit encodings are exported on the phase port
//   RED/YEL/GRN - per-head lamp patterns, ordered {red, yellow, green}
//   DIR_NS/EW  - the direction served by the most recent vehicle phase
package intersection_pkg;

  typedef enum logic [2:0] {
    RST_RED = 3'd0,
    NS_G    = 3'd1,
    NS_Y    = 3'd2,
    AR_NS   = 3'd3,
    EW_G    = 3'd4,
    EW_Y    = 3'd5,
    AR_EW   = 3'd6,
    PED     = 3'd7
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that times each controller phase.
//   clk, rst  - clock and asynchronous active-high reset (count returns to RST_VAL)
//   load      - load load_val this cycle (takes priority over counting)
//   load_val  - value loaded, i.e. phase duration minus one
//   done      - count has reached zero
module phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-road signal controller with a latched pedestrian walk phase.
//   clk, rst                      - clock, asynchronous active-high reset
//   sensor_ew                     - EW vehicle present, consulted only when NS green expires
//   ped_req                       - pedestrian button, latched into ped_pending
//   ns_red/ns_yellow/ns_green     - NS head lamps
//   ew_red/ew_yellow/ew_green     - EW head lamps
//   ped_walk                      - walk lamp
//   ped_pending                   - request latched and not yet served
//   phase                         - current state encoding
//
// state   | meaning
// RST_RED | post-reset all-red clearance
// NS_G    | NS green; minimum time, rests here while nothing is waiting
// NS_Y    | NS yellow
// AR_NS   | all-red after NS, records NS as last served
// EW_G    | EW green, fixed time
// EW_Y    | EW yellow
// AR_EW   | all-red after EW, records EW as last served
// PED     | pedestrian walk, all vehicle heads red
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 16,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_ew,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam longint MAX_CYC = longint'(1) << CNT_W;

  if (GREEN_CYC < 1 || longint'(GREEN_CYC) > MAX_CYC ||
      YELLOW_CYC < 1 || longint'(YELLOW_CYC) > MAX_CYC ||
      ALLRED_CYC < 1 || longint'(ALLRED_CYC) > MAX_CYC ||
      PED_CYC < 1 || longint'(PED_CYC) > MAX_CYC) begin : g_bad_cyc
    $error("intersection_ctrl: every *_CYC must lie in 1..2**CNT_W");
  end

  state_t           state;
  state_t           next_state;
  logic             last_dir;
  logic             done;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       ns_lamp;
  logic [2:0]       ew_lamp;

  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      NS_G, EW_G: dur_m1 = CNT_W'(GREEN_CYC - 1);
      NS_Y, EW_Y: dur_m1 = CNT_W'(YELLOW_CYC - 1);
      PED:        dur_m1 = CNT_W'(PED_CYC - 1);
      default:    dur_m1 = CNT_W'(ALLRED_CYC - 1);
    endcase
  endfunction

  // Every expiry reloads the timer, including the NS green rest, which is
  // simply a reload into the same state.
  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(ALLRED_CYC - 1))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (done),
    .load_val(load_val),
    .done    (done)
  );

  assign load_val = dur_m1(next_state);

  always_comb begin
    next_state = state;
    if (done) begin
      case (state)
        RST_RED: next_state = NS_G;
        NS_G:    next_state = (sensor_ew || ped_pending) ? NS_Y : NS_G;
        NS_Y:    next_state = AR_NS;
        AR_NS:   next_state = ped_pending ? PED : EW_G;
        EW_G:    next_state = EW_Y;
        EW_Y:    next_state = AR_EW;
        AR_EW:   next_state = ped_pending ? PED : NS_G;
        PED:     next_state = (last_dir == DIR_NS) ? EW_G : NS_G;
        default: next_state = RST_RED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_RED;
      ped_pending <= 1'b0;
      last_dir    <= DIR_EW;
    end else begin
      state <= next_state;
      if (state == AR_NS) last_dir <= DIR_NS;
      if (state == AR_EW) last_dir <= DIR_EW;
      // A press on the entry edge into PED beats the clear so it is not lost.
      if (ped_req) begin
        ped_pending <= 1'b1;
      end else if (next_state == PED && state != PED) begin
        ped_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    ns_lamp  = RED;
    ew_lamp  = RED;
    ped_walk = 1'b0;
    case (state)
      NS_G:    ns_lamp = GRN;
      NS_Y:    ns_lamp = YEL;
      EW_G:    ew_lamp = GRN;
      EW_Y:    ew_lamp = YEL;
      PED:     ped_walk = 1'b1;
      default: ;
    endcase
  end

  assign {ns_red, ns_yellow, ns_green} = ns_lamp;
  assign {ew_red, ew_yellow, ew_green} = ew_lamp;
  assign phase = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed scenarios plus randomized sensor/button/reset
// traffic, every cycle compared against a phase-age reference model.
module tb_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_ew;
  logic       ped_req;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       ped_walk, ped_pending;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  intersection_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_ew  (sensor_ew),
    .ped_req    (ped_req),
    .ns_red     (ns_red),
    .ns_yellow  (ns_yellow),
    .ns_green   (ns_green),
    .ew_red     (ew_red),
    .ew_yellow  (ew_yellow),
    .ew_green   (ew_green),
    .ped_walk   (ped_walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycles already spent in it, pending flag,
  // and whether NS was the last vehicle direction cleared.
  int m_phase, m_age, m_pending, m_last_ns;

  function automatic int dur(input int p);
    case (p)
      1, 4:    return 16;
      2, 5:    return 4;
      7:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] exp_ns(input int p);
    return (p == 1) ? 3'b001 : (p == 2) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_ew(input int p);
    return (p == 4) ? 3'b001 : (p == 5) ? 3'b010 : 3'b100;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nxt;
    if (rst) begin
      m_phase = 0; m_age = 0; m_pending = 0; m_last_ns = 0;
    end else begin
      nxt = m_phase;
      if (m_age + 1 == dur(m_phase)) begin
        m_age = 0;
        case (m_phase)
          0: nxt = 1;
          1: nxt = (sensor_ew || m_pending != 0) ? 2 : 1;
          2: nxt = 3;
          3: nxt = (m_pending != 0) ? 7 : 4;
          4: nxt = 5;
          5: nxt = 6;
          6: nxt = (m_pending != 0) ? 7 : 1;
          default: nxt = (m_last_ns != 0) ? 4 : 1;
        endcase
      end else begin
        m_age++;
      end
      if (m_phase == 3) m_last_ns = 1;
      if (m_phase == 6) m_last_ns = 0;
      if (ped_req) m_pending = 1;
      else if (nxt == 7 && m_phase != 7) m_pending = 0;
      m_phase = nxt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("ns_lamps", 32'({ns_red, ns_yellow, ns_green}), 32'(exp_ns(m_phase)));
    chk("ew_lamps", 32'({ew_red, ew_yellow, ew_green}), 32'(exp_ew(m_phase)));
    chk("walk", 32'(ped_walk), 32'(m_phase == 7));
    chk("pending", 32'(ped_pending), 32'(m_pending));
    chk("exclusive", 32'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 32'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic wait_entry(input logic [2:0] p, input int max, output int cyc);
    logic [2:0] prev;
    bit hit;
    prev = phase;
    hit  = 0;
    cyc  = 0;
    while (!hit && cyc < max) begin
      step(1);
      cyc++;
      if (phase == p && prev != p) hit = 1;
      prev = phase;
    end
    if (!hit) chk("wait_entry", 32'(phase), 32'(p));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    rst = 1'b1; sensor_ew = 1'b0; ped_req = 1'b0;
    step(3);

    // Release: RST_RED for two cycles, then NS green and rest there.
    rst = 1'b0;
    step(1);
    chk("rst_red_c1", 32'(phase), 32'd0);
    step(1);
    chk("ns_g_c2", 32'(phase), 32'd1);
    step(200);
    chk("ns_rest", 32'(phase), 32'd1);

    // Continuous EW demand: full cycle period.
    sensor_ew = 1'b1;
    wait_entry(3'd1, 100, c);
    wait_entry(3'd1, 100, c);
    chk("period", 32'(c), 32'd44);

    // Button during EW green, then walk, then back to NS.
    wait_entry(3'd4, 60, c);
    sensor_ew = 1'b0;
    step(3);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    chk("pend_set", 32'(ped_pending), 32'd1);
    wait_entry(3'd7, 60, c);
    chk("pend_clr", 32'(ped_pending), 32'd0);
    n = 0;
    c = 0;
    while (phase == 3'd7 && c < 20) begin
      n += int'(ped_walk);
      c++;
      step(1);
    end
    chk("walk_len", 32'(n), 32'd8);
    chk("after_ped_ew", 32'(phase), 32'd1);

    // Button during NS rest, plus a press on the edge entering PED.
    step(20);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    wait_entry(3'd3, 60, c);
    step(1);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    chk("ped_entry", 32'(phase), 32'd7);
    chk("pend_keep", 32'(ped_pending), 32'd1);
    wait_entry(3'd4, 20, c);
    chk("ped_to_ewg", 32'(c), 32'd8);
    wait_entry(3'd7, 60, c);
    chk("second_walk", 32'(c), 32'd22);
    wait_entry(3'd1, 20, c);
    chk("ped_to_nsg", 32'(c), 32'd8);

    // Asynchronous reset in the middle of EW yellow.
    sensor_ew = 1'b1;
    wait_entry(3'd5, 80, c);
    step(1);
    #2 rst = 1'b1;
    #1;
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_ns", 32'({ns_red, ns_yellow, ns_green}), 32'(3'b100));
    chk("async_ew", 32'({ew_red, ew_yellow, ew_green}), 32'(3'b100));
    step(1);
    rst = 1'b0;
    step(1);
    chk("rst2_c1", 32'(phase), 32'd0);
    step(1);
    chk("rst2_c2", 32'(phase), 32'd1);
    chk("rst2_pend", 32'(ped_pending), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sensor_ew = ~sensor_ew;
      ped_req = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 399) == 0);
      step(1);
    end
    rst = 1'b0;
    ped_req = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
